// File: rtl/tpu_pkg.sv
// Shared definitions for the tile sequencer: FSM state encoding and
// default array/timeout constants.
package tpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_READ,
        S_COMPUTE,
        S_WRITE_WAIT,
        S_WRITE,
        S_ADVANCE,
        S_FINISH
    } seq_state_t;

    localparam int unsigned DEFAULT_ARRAY_SIZE = 2;
    localparam int unsigned DEFAULT_TIMEOUT    = 1024;

endpackage

// File: rtl/tile_sequencer_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the phase has lasted TIMEOUT cycles.
module phase_timer import tpu_pkg::*; #(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Saturates at LAST; the sequencer leaves the phase on expiry anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/tile_sequencer.sv
// Walks a job of rows x cols tiles through read/compute/write phases,
// handling FIFO back-pressure, per-phase timeout and abort.
module tile_sequencer import tpu_pkg::*; #(
    parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [CNT_W-1:0] job_rows_i,
    input  logic [CNT_W-1:0] job_cols_i,
    input  logic             abort_i,
    input  logic             rempty_i,
    input  logic             wfull_i,
    output logic             read_start_o,
    output logic             compute_start_o,
    output logic             write_start_o,
    input  logic             read_done_i,
    input  logic             compute_done_i,
    input  logic             write_done_i,
    output logic [CNT_W-1:0] tile_row_o,
    output logic [CNT_W-1:0] tile_col_o,
    output logic             job_done_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if ((TIMEOUT < 2) || (ARRAY_SIZE < 1)) begin : g_param_check
        $error("tile_sequencer: TIMEOUT must be >= 2 and ARRAY_SIZE >= 1");
    end

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic [CNT_W-1:0] tile_row_q, tile_row_d, tile_col_q, tile_col_d;
    logic             err_q, err_d;
    logic             timer_en, timer_clr, timer_expired;
    logic             last_col, last_row;

    assign timer_en  = (state_q == S_READ) || (state_q == S_COMPUTE) || (state_q == S_WRITE);
    assign timer_clr = !timer_en || (state_d != state_q);
    assign last_col  = (tile_col_q == cols_q - ONE);
    assign last_row  = (tile_row_q == rows_q - ONE);

    phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clr),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        tile_row_d = tile_row_q;
        tile_col_d = tile_col_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    rows_d     = (job_rows_i == '0) ? ONE : job_rows_i;
                    cols_d     = (job_cols_i == '0) ? ONE : job_cols_i;
                    tile_row_d = '0;
                    tile_col_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_READ_WAIT;
                end
            end
            S_READ_WAIT: if (!rempty_i) state_d = S_READ;
            S_READ: begin
                if (read_done_i) state_d = S_COMPUTE;
                else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_COMPUTE: begin
                if (compute_done_i) state_d = S_WRITE_WAIT;
                else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_WRITE_WAIT: if (!wfull_i) state_d = S_WRITE;
            S_WRITE: begin
                if (write_done_i) state_d = S_ADVANCE;
                else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_ADVANCE: begin
                if (last_col) begin
                    tile_col_d = '0;
                    tile_row_d = tile_row_q + ONE;
                end else begin
                    tile_col_d = tile_col_q + ONE;
                end
                state_d = (last_row && last_col) ? S_FINISH : S_READ_WAIT;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides everything in flight; FINISH already ends the job.
        if (abort_i && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
            state_d    = S_FINISH;
            err_d      = err_q;
            tile_row_d = tile_row_q;
            tile_col_d = tile_col_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rows_q     <= ONE;
            cols_q     <= ONE;
            tile_row_q <= '0;
            tile_col_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            tile_row_q <= tile_row_d;
            tile_col_q <= tile_col_d;
            err_q      <= err_d;
        end
    end

    assign job_ready_o     = (state_q == S_IDLE);
    assign read_start_o    = (state_q == S_READ);
    assign compute_start_o = (state_q == S_COMPUTE);
    assign write_start_o   = (state_q == S_WRITE);
    assign job_done_o      = (state_q == S_FINISH);
    assign tile_row_o      = tile_row_q;
    assign tile_col_o      = tile_col_q;
    assign err_o           = err_q;

endmodule
